// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency imem,
// and fills the IF/ID register through a 1-entry skid buffer.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_v_q, inflight_v_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;

    logic        src_v;
    logic [31:0] src_instr;
    logic [31:0] src_pc;

    // Oldest pending word: the skid always predates anything in flight.
    always_comb begin
        src_v     = 1'b0;
        src_instr = NOP_INSTR;
        src_pc    = if_id_pc_q;
        if (skid_v_q) begin
            src_v     = 1'b1;
            src_instr = skid_instr_q;
            src_pc    = skid_pc_q;
        end else if (inflight_v_q) begin
            src_v     = 1'b1;
            src_instr = imem_rdata;
            src_pc    = inflight_pc_q;
        end
    end

    always_comb begin
        pc_d             = pc_q;
        inflight_v_d     = inflight_v_q;
        inflight_pc_d    = inflight_pc_q;
        skid_v_d         = skid_v_q;
        skid_instr_d     = skid_instr_q;
        skid_pc_d        = skid_pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;

        if (redirect) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            inflight_v_d  = 1'b0;
            skid_v_d      = 1'b0;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (stall) begin
            if (inflight_v_q) begin
                skid_v_d     = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = inflight_pc_q;
                inflight_v_d = 1'b0;
            end
        end else begin
            if_id_valid_d    = src_v;
            if_id_instr_d    = src_v ? src_instr : NOP_INSTR;
            if_id_pc_d       = src_pc;
            if_id_pc_plus4_d = src_pc + 32'd4;
            skid_v_d         = 1'b0;
            inflight_v_d     = 1'b1;
            inflight_pc_d    = pc_q;
            pc_d             = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            inflight_v_q     <= 1'b0;
            inflight_pc_q    <= 32'd0;
            skid_v_q         <= 1'b0;
            skid_instr_q     <= 32'd0;
            skid_pc_q        <= 32'd0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
        end else begin
            pc_q             <= pc_d;
            inflight_v_q     <= inflight_v_d;
            inflight_pc_q    <= inflight_pc_d;
            skid_v_q         <= skid_v_d;
            skid_instr_q     <= skid_instr_d;
            skid_pc_q        <= skid_pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
        end
    end

    assign imem_req       = !rst && !redirect && !stall;
    assign imem_addr      = pc_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: program-order model of the
// fetched stream versus what the IF/ID register hands downstream.
module tb_if_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;

    if_fetch_stage #(
        .RESET_PC (RPC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: word = A000_0000 + addr one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 + imem_addr;
        else          imem_rdata <= $urandom;
    end

    typedef struct {
        logic [31:0] pc;
        bit          ready;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_pc;
    bit          armed;
    bit          after_rst;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model advances on the edge that consumes it.
    task automatic step(input logic r, input logic s, input logic d,
                        input logic [31:0] t);
        ent_t e;
        rst         = r;
        stall       = s;
        redirect    = d;
        redirect_pc = t;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_pc    = RPC;
            after_rst = 1'b1;
            armed     = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (d) begin
                q.delete();
                exp_pc = {t[31:2], 2'b00};
            end else if (!s) begin
                foreach (q[i]) q[i].ready = 1'b1;
                e.pc    = exp_pc;
                e.ready = 1'b0;
                q.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    // Monitor: IF/ID must show the oldest un-flushed fetch once it has
    // had an advancing cycle to arrive; downstream takes it when not stalled.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("invariant", {31'd0, dut.skid_v_q && dut.inflight_v_q}, 32'd0);
                chk("imem_req", {31'd0, imem_req},
                    {31'd0, !rst && !redirect && !stall});
                chk("imem_addr", imem_addr, exp_pc);
                exp_v = 1'b0;
                if (q.size() > 0) exp_v = q[0].ready;
                chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, exp_v});
                if (after_rst) begin
                    chk("reset_pc", if_id_pc, 32'd0);
                    chk("reset_pc4", if_id_pc_plus4, 32'd0);
                end
                if (!if_id_valid) chk("bubble_instr", if_id_instr, NOP);
                if (if_id_valid && exp_v) begin
                    chk("if_id_pc", if_id_pc, q[0].pc);
                    chk("if_id_instr", if_id_instr, 32'hA000_0000 + q[0].pc);
                    chk("if_id_pc4", if_id_pc_plus4, q[0].pc + 32'd4);
                    if (!rst && !redirect && !stall) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        logic [31:0] t;
        checks    = 0;
        errors    = 0;
        armed     = 1'b0;
        after_rst = 1'b0;
        exp_pc    = RPC;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        // sequential start, then 1-cycle stall with 0x8 in flight
        run(3);
        hold(1);
        run(3);
        // 3-cycle stall
        hold(3);
        run(3);
        // redirect to unaligned target, then redirect overriding stall
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        run(4);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        run(4);
        // redirect while the skid holds a word
        run(2);
        hold(2);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0400);
        run(4);
        // wrap-around, then reset mid-stream
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run(4);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        run(4);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            if (r < 1)
                step(1'b1, $urandom_range(0, 1) == 0, 1'b0, 32'd0);
            else if (r < 6)
                step(1'b0, $urandom_range(0, 2) == 0, 1'b1, t);
            else
                step(1'b0, $urandom_range(0, 3) == 0, 1'b0, 32'd0);
        end
        run(4);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
